// File: rtl/spart_pkg.sv
// Shared SPART bus constants and arbiter state encoding.
// Latency: none (package only).
// Backpressure: n/a.
package spart_pkg;

   // SPART processor-side register map (ioaddr)
   localparam logic [1:0] ADDR_DATA   = 2'b00;
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_DB_LO  = 2'b10;
   localparam logic [1:0] ADDR_DB_HI  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      XFER = 2'b01,
      DONE = 2'b10
   } arb_state_t;

endpackage

// File: rtl/spart_bus_arbiter_rr_pick.sv
// Round-robin selector: first eligible client at or after ptr_i, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; found_o low when no client is eligible.
// Ports: elig_i  - per-client eligible vector
//        ptr_i   - index that has highest priority this round
//        found_o - at least one client eligible
//        idx_o   - winning client index (0 when found_o is low)
module rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     elig_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   // One extra bit so ptr + offset can exceed N before the wrap.
   logic [IDX_W:0] cand;

   // Walk offsets from farthest to nearest so the nearest eligible client
   // (smallest offset from ptr) is the last assignment and therefore wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
         if (cand >= (IDX_W + 1)'(N)) begin
            cand = cand - (IDX_W + 1)'(N);
         end
         if (elig_i[cand[IDX_W-1:0]]) begin
            found_o = 1'b1;
            idx_o   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/spart_bus_arbiter.sv
// Shares the SPART processor bus among NUM_REQ single-byte requesters, round-robin.
// Latency: eligible in cycle N -> bus cycle (iocs) in N+1 -> done pulse + rdata in N+2.
// Backpressure: DATA accesses wait in req until rda (read) / tbr (write); req held until done.
// Ports: clk, rst_n (async active-low)
//        req/req_we/req_addr/req_wdata - per-requester transaction (flattened, 2 and 8 bits each)
//        gnt (one-hot owner), done (1-cycle completion), rdata (last read byte, held)
//        rda/tbr (SPART status), iocs/iorw/ioaddr/databus (SPART processor bus)
module spart_bus_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   req_we,
   input  logic [2*NUM_REQ-1:0] req_addr,
   input  logic [8*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   done,
   output logic [7:0]           rdata,
   input  logic                 rda,
   input  logic                 tbr,
   output logic                 iocs,
   output logic                 iorw,
   output logic [1:0]           ioaddr,
   inout  wire  [7:0]           databus
);
   import spart_pkg::*;

   arb_state_t         state_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   ptr_d;
   logic [IDX_W-1:0]   idx_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic [NUM_REQ-1:0] gnt_d;
   logic [NUM_REQ-1:0] done_q;
   logic               we_q;
   logic [7:0]         wdata_q;
   logic [7:0]         rdata_q;
   logic               iocs_q;
   logic               iorw_q;
   logic [1:0]         ioaddr_q;
   logic               drive_q;

   logic [NUM_REQ-1:0] elig;
   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic               sel_we;
   logic [1:0]         sel_addr;
   logic [7:0]         sel_wdata;

   // Only the DATA register is gated by SPART readiness; STATUS and the
   // divisor bytes can always be accessed.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = req[i] &&
                   !((req_addr[2*i +: 2] == ADDR_DATA) && (req_we[i] ? !tbr : !rda));
      end
   end

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .elig_i  (elig),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Mux out the winner's request fields.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = ADDR_DATA;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == pick_idx) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[2*i +: 2];
            sel_wdata = req_wdata[8*i +: 8];
         end
      end
   end

   assign gnt_d = NUM_REQ'(1) << pick_idx;
   assign ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

   // All bus outputs are registered: they are loaded on the edge entering
   // the state in which they must be valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         idx_q    <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         iocs_q   <= 1'b0;
         iorw_q   <= 1'b1;
         ioaddr_q <= ADDR_DATA;
         drive_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= '0;
               if (pick_found) begin
                  idx_q    <= pick_idx;
                  we_q     <= sel_we;
                  wdata_q  <= sel_wdata;
                  gnt_q    <= gnt_d;
                  iocs_q   <= 1'b1;
                  iorw_q   <= ~sel_we;
                  ioaddr_q <= sel_addr;
                  drive_q  <= sel_we;
                  state_q  <= XFER;
               end
            end
            XFER: begin
               // SPART read data is sampled at the edge that closes the bus cycle.
               if (!we_q) begin
                  rdata_q <= databus;
               end
               done_q   <= gnt_q;
               iocs_q   <= 1'b0;
               iorw_q   <= 1'b1;
               ioaddr_q <= ADDR_DATA;
               drive_q  <= 1'b0;
               state_q  <= DONE;
            end
            DONE: begin
               done_q  <= '0;
               gnt_q   <= '0;
               ptr_q   <= ptr_d;
               state_q <= IDLE;
            end
            default: begin
               done_q   <= '0;
               gnt_q    <= '0;
               iocs_q   <= 1'b0;
               iorw_q   <= 1'b1;
               ioaddr_q <= ADDR_DATA;
               drive_q  <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign rdata   = rdata_q;
   assign iocs    = iocs_q;
   assign iorw    = iorw_q;
   assign ioaddr  = ioaddr_q;
   // drive_q is cleared asynchronously by reset, releasing the bus at once.
   assign databus = drive_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Self-checking bench for spart_bus_arbiter (two requesters) with a transaction scoreboard.
// Latency: checks bus cycle at N+1 and done at N+2 after a request becomes eligible.
// Backpressure: exercises rda/tbr gating of DATA accesses and req held through done.
module tb_spart_bus_arbiter;
   import spart_pkg::*;

   localparam int         NR   = 2;
   // Byte the SPART model parks on databus whenever the arbiter is not
   // writing; any stray arbiter drive corrupts it and shows up in checks.
   localparam logic [7:0] KEEP = 8'h3C;

   typedef struct packed {
      logic [1:0] who;
      logic       we;
      logic [1:0] addr;
      logic [7:0] data;
   } txn_t;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic [NR-1:0]   req;
   logic [NR-1:0]   req_we;
   logic [2*NR-1:0] req_addr;
   logic [8*NR-1:0] req_wdata;
   logic [NR-1:0]   gnt;
   logic [NR-1:0]   done;
   logic [7:0]      rdata;
   logic            rda;
   logic            tbr;
   logic            iocs;
   logic            iorw;
   logic [1:0]      ioaddr;
   wire  [7:0]      databus;
   logic [7:0]      rd_byte;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int done_total = 0;

   txn_t exp_q[$];
   txn_t obs_q[$];
   int   obs_cyc[$];
   txn_t e, o, mon_o;
   int   c, prev_c, k;
   bit   ok;
   int   d0;

   logic [1:0] bus_gnt;
   logic       bus_we;
   logic [1:0] bus_addr;
   logic [7:0] bus_data;
   bit         bus_pend = 1'b0;

   spart_bus_arbiter #(.NUM_REQ(NR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .done      (done),
      .rdata     (rdata),
      .rda       (rda),
      .tbr       (tbr),
      .iocs      (iocs),
      .iorw      (iorw),
      .ioaddr    (ioaddr),
      .databus   (databus)
   );

   // SPART model: returns rd_byte on a read cycle, releases the bus on a write cycle.
   assign databus = (iocs && !iorw) ? 8'hzz : ((iocs && iorw) ? rd_byte : KEEP);

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: pairs each bus cycle with the done pulse that closes it.
   initial forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
         bus_pend = 1'b0;
      end else begin
         if (iocs === 1'b1) begin
            bus_gnt  = gnt;
            bus_we   = !iorw;
            bus_addr = ioaddr;
            bus_data = databus;
            bus_pend = 1'b1;
         end
         if (done !== '0) begin
            done_total++;
            mon_o.who  = (bus_pend && bus_gnt == done && gnt == done) ? done : 2'b00;
            mon_o.we   = bus_we;
            mon_o.addr = bus_addr;
            mon_o.data = bus_we ? bus_data : rdata;
            obs_q.push_back(mon_o);
            obs_cyc.push_back(cyc);
            bus_pend = 1'b0;
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   function automatic txn_t mk(input int w, input logic we, input logic [1:0] a, input logic [7:0] d);
      txn_t t;
      t.who  = 2'b01 << w;
      t.we   = we;
      t.addr = a;
      t.data = d;
      return t;
   endfunction

   task automatic set_req(input int i, input logic r, input logic we, input logic [1:0] a, input logic [7:0] d);
      req[i]             = r;
      req_we[i]          = we;
      req_addr[2*i +: 2] = a;
      req_wdata[8*i +: 8] = d;
   endtask

   task automatic wait_obs(input int n, input int budget, output bit got);
      int w = 0;
      while (obs_q.size() < n && w < budget) begin
         @(negedge clk);
         #1;
         w++;
      end
      got = (obs_q.size() >= n);
   endtask

   task automatic test_reset;
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      rda = 1'b0; tbr = 1'b1; rd_byte = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b want 00", gnt); end
      total++; if (done !== 2'b00) begin bad++; $display("FAIL rst_done: got %b want 00", done); end
      total++; if (iocs !== 1'b0) begin bad++; $display("FAIL rst_iocs: got %b want 0", iocs); end
      total++; if (iorw !== 1'b1) begin bad++; $display("FAIL rst_iorw: got %b want 1", iorw); end
      total++; if (ioaddr !== 2'b00) begin bad++; $display("FAIL rst_ioaddr: got %b want 00", ioaddr); end
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata: got %h want 00", rdata); end
      total++; if (databus !== KEEP) begin bad++; $display("FAIL rst_databus: got %h want %h (undriven)", databus, KEEP); end
      rst_n = 1'b1;
   endtask

   task automatic test_write_dblo;
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b1, ADDR_DB_LO, 8'h80);
      exp_q.push_back(mk(0, 1'b1, ADDR_DB_LO, 8'h80));
      @(negedge clk);
      total++; if (iocs !== 1'b0) begin bad++; $display("FAIL wr_idle: iocs %b want 0", iocs); end
      @(negedge clk);
      total++;
      if ({iocs, iorw, ioaddr, databus, gnt} !== {1'b1, 1'b0, 2'b10, 8'h80, 2'b01}) begin
         bad++;
         $display("FAIL wr_xfer: iocs=%b iorw=%b ioaddr=%b databus=%h gnt=%b want 1 0 10 80 01", iocs, iorw, ioaddr, databus, gnt);
      end
      @(negedge clk);
      total++;
      if ({done, gnt, iocs, databus} !== {2'b01, 2'b01, 1'b0, KEEP}) begin
         bad++;
         $display("FAIL wr_done: done=%b gnt=%b iocs=%b databus=%h want 01 01 0 %h", done, gnt, iocs, databus, KEEP);
      end
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, ADDR_DATA, 8'h00);
      @(negedge clk);
      total++; if ({done, iocs} !== 3'b000) begin bad++; $display("FAIL wr_after: done=%b iocs=%b want 00 0", done, iocs); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL wr_sb: no transaction, expected %h", e); end
         else begin
            o = obs_q.pop_front(); c = obs_cyc.pop_front();
            if (o !== e) begin bad++; $display("FAIL wr_sb: got %h expected %h", o, e); end
         end
      end
      total++;
      if (obs_q.size() != 0) begin bad++; $display("FAIL wr_extra: %0d unexpected transactions", obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
   endtask

   task automatic test_read_gated;
      @(posedge clk); #1;
      rda = 1'b0; rd_byte = 8'h5A;
      set_req(1, 1'b1, 1'b0, ADDR_DATA, 8'h00);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (gnt !== 2'b00 || iocs !== 1'b0) begin bad++; $display("FAIL rd_gated: cycle %0d gnt=%b iocs=%b want 00 0", i, gnt, iocs); end
      end
      @(posedge clk); #1;
      rda = 1'b1;
      exp_q.push_back(mk(1, 1'b0, ADDR_DATA, 8'h5A));
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({iocs, iorw, ioaddr, gnt} !== {1'b1, 1'b1, 2'b00, 2'b10}) begin
         bad++;
         $display("FAIL rd_xfer: iocs=%b iorw=%b ioaddr=%b gnt=%b want 1 1 00 10", iocs, iorw, ioaddr, gnt);
      end
      @(negedge clk);
      total++;
      if ({done, rdata} !== {2'b10, 8'h5A}) begin bad++; $display("FAIL rd_done: done=%b rdata=%h want 10 5a", done, rdata); end
      @(posedge clk); #1;
      set_req(1, 1'b0, 1'b0, ADDR_DATA, 8'h00);
      rda = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL rd_sb: no transaction, expected %h", e); end
         else begin
            o = obs_q.pop_front(); c = obs_cyc.pop_front();
            if (o !== e) begin bad++; $display("FAIL rd_sb: got %h expected %h", o, e); end
         end
      end
      total++;
      if (obs_q.size() != 0) begin bad++; $display("FAIL rd_extra: %0d unexpected transactions", obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
   endtask

   task automatic test_alternate;
      @(negedge clk);
      rst_n = 1'b0;
      rda = 1'b0; tbr = 1'b0; rd_byte = 8'h33;
      set_req(0, 1'b1, 1'b0, ADDR_STATUS, 8'h00);
      set_req(1, 1'b1, 1'b0, ADDR_STATUS, 8'h00);
      for (int i = 0; i < 6; i++) exp_q.push_back(mk(i % 2, 1'b0, ADDR_STATUS, 8'h33));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_obs(6, 40, ok);
      total++; if (!ok) begin bad++; $display("FAIL alt_timeout: got %0d of 6 transactions", obs_q.size()); end
      @(posedge clk); #1;
      req = '0;
      repeat (3) @(negedge clk);
      k = 0; prev_c = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL alt_sb: no transaction, expected %h", e); end
         else begin
            o = obs_q.pop_front(); c = obs_cyc.pop_front();
            if (o !== e) begin bad++; $display("FAIL alt_sb: txn %0d got %h expected %h", k, o, e); end
            if (k > 0) begin
               total++;
               if (c - prev_c != 3) begin bad++; $display("FAIL alt_spacing: txn %0d gap %0d cycles want 3", k, c - prev_c); end
            end
            prev_c = c;
         end
         k++;
      end
      total++;
      if (obs_q.size() != 0) begin bad++; $display("FAIL alt_extra: %0d unexpected transactions", obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
   endtask

   task automatic test_priority;
      @(posedge clk); #1;
      tbr = 1'b0; rda = 1'b0; rd_byte = 8'h21;
      set_req(0, 1'b1, 1'b1, ADDR_DATA, 8'h41);
      set_req(1, 1'b1, 1'b0, ADDR_STATUS, 8'h00);
      exp_q.push_back(mk(1, 1'b0, ADDR_STATUS, 8'h21));
      wait_obs(1, 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL pri_r1_timeout: R1 not served"); end
      @(posedge clk); #1;
      set_req(1, 1'b0, 1'b0, ADDR_DATA, 8'h00);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (iocs !== 1'b0) begin bad++; $display("FAIL pri_blocked: cycle %0d iocs=%b gnt=%b want 0 with tbr low", i, iocs, gnt); end
      end
      @(posedge clk); #1;
      tbr = 1'b1;
      exp_q.push_back(mk(0, 1'b1, ADDR_DATA, 8'h41));
      wait_obs(2, 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL pri_r0_timeout: R0 not served after tbr"); end
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, ADDR_DATA, 8'h00);
      repeat (3) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL pri_sb: no transaction, expected %h", e); end
         else begin
            o = obs_q.pop_front(); c = obs_cyc.pop_front();
            if (o !== e) begin bad++; $display("FAIL pri_sb: got %h expected %h", o, e); end
         end
      end
      total++;
      if (obs_q.size() != 0) begin bad++; $display("FAIL pri_extra: %0d unexpected transactions", obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
   endtask

   task automatic test_reset_mid;
      // ptr points at R1 here (R0 was served last), so R0 winning a tie
      // after reset shows ptr was cleared.
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b1, ADDR_DB_HI, 8'h99);
      d0 = done_total;
      @(negedge clk);
      @(negedge clk);
      total++; if (iocs !== 1'b1 || databus !== 8'h99) begin bad++; $display("FAIL mid_xfer: iocs=%b databus=%h want 1 99", iocs, databus); end
      rst_n = 1'b0;
      #1;
      total++;
      if ({iocs, gnt, databus} !== {1'b0, 2'b00, KEEP}) begin
         bad++;
         $display("FAIL mid_abort: iocs=%b gnt=%b databus=%h want 0 00 %h", iocs, gnt, databus, KEEP);
      end
      set_req(0, 1'b0, 1'b0, ADDR_DATA, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      total++; if (done_total != d0) begin bad++; $display("FAIL mid_nodone: %0d done pulses after abort want 0", done_total - d0); end
      total++; if (rdata !== 8'h00) begin bad++; $display("FAIL mid_rdata: got %h want 00", rdata); end
      @(posedge clk); #1;
      rd_byte = 8'h77;
      set_req(0, 1'b1, 1'b0, ADDR_STATUS, 8'h00);
      set_req(1, 1'b1, 1'b0, ADDR_STATUS, 8'h00);
      exp_q.push_back(mk(0, 1'b0, ADDR_STATUS, 8'h77));
      exp_q.push_back(mk(1, 1'b0, ADDR_STATUS, 8'h77));
      wait_obs(2, 15, ok);
      total++; if (!ok) begin bad++; $display("FAIL mid_timeout: got %0d of 2 transactions", obs_q.size()); end
      @(posedge clk); #1;
      req = '0;
      repeat (3) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL mid_sb: no transaction, expected %h", e); end
         else begin
            o = obs_q.pop_front(); c = obs_cyc.pop_front();
            if (o !== e) begin bad++; $display("FAIL mid_sb: got %h expected %h", o, e); end
         end
      end
      total++;
      if (obs_q.size() != 0) begin bad++; $display("FAIL mid_extra: %0d unexpected transactions", obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
   endtask

   task automatic test_back_to_back;
      @(posedge clk); #1;
      set_req(1, 1'b1, 1'b1, ADDR_DB_LO, 8'h11);
      exp_q.push_back(mk(1, 1'b1, ADDR_DB_LO, 8'h11));
      exp_q.push_back(mk(1, 1'b1, ADDR_DB_LO, 8'h11));
      wait_obs(2, 15, ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got %0d of 2 transactions", obs_q.size()); end
      @(posedge clk); #1;
      set_req(1, 1'b0, 1'b0, ADDR_DATA, 8'h00);
      repeat (4) @(negedge clk);
      k = 0; prev_c = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL b2b_sb: no transaction, expected %h", e); end
         else begin
            o = obs_q.pop_front(); c = obs_cyc.pop_front();
            if (o !== e) begin bad++; $display("FAIL b2b_sb: txn %0d got %h expected %h", k, o, e); end
            if (k > 0) begin
               total++;
               if (c - prev_c != 3) begin bad++; $display("FAIL b2b_spacing: gap %0d cycles want 3", c - prev_c); end
            end
            prev_c = c;
         end
         k++;
      end
      total++;
      if (obs_q.size() != 0) begin bad++; $display("FAIL b2b_extra: %0d unexpected transactions", obs_q.size()); obs_q.delete(); obs_cyc.delete(); end
   endtask

   initial begin
      test_reset();
      test_write_dblo();
      test_read_gated();
      test_alternate();
      test_priority();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
